enokida_trace_buffer: RTL
=========================

# enokida_trace_buffer

Upstream feeder for the trace-assisted n-way cache. It captures 160-bit trace records from the tracer and holds them in a show-ahead FIFO. It presents the head record to the cache on `trace_in` / `trace_ready`, and drives the cache's `trace_capture_enable` and `lock` inputs. It also applies back-pressure with hysteresis and keeps overflow statistics.

## Interface
- `TRACE_WIDTH`, 160, record width; must match cache `trace_in`.
- `DEPTH`, 8, FIFO entries; power of two, ≥4.
- `LOCK_HI`, DEPTH-2, occupancy at or above which `lock_o` sets.
- `LOCK_LO`, 2, occupancy at or below which `lock_o` clears; LOCK_LO < LOCK_HI.
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `capture_en_i`  in  1  software capture enable.
- `clear_i`  in  1  synchronous flush of FIFO and statistics.
- `tracer_valid_i`  in  1  tracer offers a record this cycle.
- `tracer_data_i`  in  TRACE_WIDTH  offered record.
- `tracer_ready_o`  out  1  FIFO not full.
- `trace_out_o`  out  TRACE_WIDTH  head record, to cache `trace_in`.
- `trace_ready_o`  out  1  head valid (FIFO not empty), to cache `trace_ready`.
- `trace_pop_i`  in  1  cache consumes the head record.
- `trace_capture_enable_o`  out  1  to cache `trace_capture_enable`.
- `lock_o`  out  1  to cache `lock`.
- `occupancy_o`  out  $clog2(DEPTH)+1  entries held.
- `overflow_o`  out  1  sticky: a record was dropped.
- `drop_count_o`  out  16  dropped records, saturating.

## Operation
- **Storage.** Circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a separate occupancy counter.
- **Push.** Occurs when `tracer_valid_i & capture_en_i & !full`. The record is written at `wr_ptr` and `wr_ptr` increments.
- **Drop.** Occurs when `tracer_valid_i & capture_en_i & full`, even if `trace_pop_i` is high that cycle.
  - Nothing is written.
  - `overflow_o` sets.
  - `drop_count_o` increments, saturating at 16'hFFFF.
- **Ignored offers.** Offers while `capture_en_i`=0 are discarded silently, with no drop accounting.
- **Pop.** Occurs when `trace_pop_i & !empty`; `rd_ptr` increments. A pop while empty is ignored.
- **Push and pop together** (non-empty, non-full): both happen and occupancy is unchanged.
- **Push and pop on empty:** the pop is ignored and the push proceeds.
- **Head output.** `trace_out_o` = `mem[rd_ptr]`, combinational from storage. It is don't-care while `trace_ready_o`=0.
- **`trace_ready_o`** = (occupancy != 0). **`tracer_ready_o`** = (occupancy != DEPTH). Both are derived from registered occupancy only.
- **Lock (hysteresis).**
  - `lock_o` sets when the next occupancy is ≥ LOCK_HI.
  - `lock_o` clears when the next occupancy is ≤ LOCK_LO.
  - Otherwise it holds.
- **`trace_capture_enable_o`:** registered `capture_en_i & !overflow_next`. It stays low after any overflow until `clear_i`.
- **`clear_i`** has priority over push and pop in the same cycle. It:
  - zeroes the pointers and occupancy;
  - clears `overflow_o`, `drop_count_o` and `lock_o`;
  - leaves storage contents don't-care.
- **Reset** (`rst_n`=0 at an edge) has the same effect as `clear_i`, and also forces `trace_capture_enable_o`=0. Reset applied in the middle of traffic discards all records.

## Timing
- **Reset values:**
  - `occupancy_o`=0, `trace_ready_o`=0, `tracer_ready_o`=1.
  - `lock_o`=0, `overflow_o`=0, `drop_count_o`=0, `trace_capture_enable_o`=0.
  - `trace_out_o` is don't-care.
- **Push latency.** A record pushed at edge N is visible on `trace_out_o` with `trace_ready_o`=1 after edge N, provided the FIFO was empty.
- **Pop.** The cache samples `trace_out_o` in the same cycle it asserts `trace_pop_i`. The next record, if any, appears after that edge.
- **Status signals.** `occupancy_o`, `lock_o`, `overflow_o` and `drop_count_o` all update on the same edge as the push, pop or drop that causes the change.
- **Capture enable.** `trace_capture_enable_o` follows `capture_en_i` with one cycle of latency.
- **No combinational paths:**
  - none from `trace_pop_i` to `tracer_ready_o`;
  - none from `tracer_valid_i` to `trace_ready_o`.
- **Throughput.** One push and one pop per cycle, sustained.

## Test plan
- **Basic flow.** Reset, then `capture_en_i`=1, then push records 0xA..A1, 0xA..A2, 0xA..A3 on consecutive cycles with no pops.
  - Required: `occupancy_o` reads 1, 2, 3; `trace_out_o`=A1 throughout.
  - Then three pops: the outputs are A1, A2, A3 in order, then `trace_ready_o`=0.
- **Fill and overflow** (DEPTH=8). Push 10 records with no pops.
  - Required: `occupancy_o`=8 and `tracer_ready_o`=0; `drop_count_o`=2 and `overflow_o`=1.
  - `trace_capture_enable_o`=0 one cycle after the first drop.
  - Popping all 8 returns the first 8 records in order.
- **Lock hysteresis** (LOCK_HI=6, LOCK_LO=2).
  - Fill to 6: `lock_o` rises on the edge where occupancy reaches 6.
  - Pop to 3: `lock_o` stays 1.
  - Pop to 2: `lock_o` falls.
- **Simultaneous events.**
  - At occupancy 4, push and pop together for 20 cycles: occupancy stays 4 and the data order is preserved.
  - At occupancy 0, push and pop together: occupancy becomes 1.
  - At full, push and pop together: the pop succeeds, the push is dropped, `drop_count_o` increments, and occupancy becomes 7.
- **Clear and reset in the middle of traffic.**
  - At occupancy 5 with `overflow_o`=1, assert `clear_i` together with a push. Required after that edge: occupancy 0, no flags set, `drop_count_o`=0, the push discarded.
  - Repeat with `rst_n`=0: identical result, plus `trace_capture_enable_o`=0.
- **Gating and saturation.**
  - Offers with `capture_en_i`=0 change nothing.
  - Force 70000 drops: `drop_count_o` holds at 16'hFFFF.

Source files
------------

// File: rtl/enokida_trace_buffer.sv
// Show-ahead trace FIFO feeding the trace-assisted cache: hysteresis lock,
// sticky overflow with saturating drop counter, and registered capture enable.
module enokida_trace_buffer #(
  parameter int TRACE_WIDTH = 160,
  parameter int DEPTH       = 8,
  parameter int LOCK_HI     = DEPTH - 2,
  parameter int LOCK_LO     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     capture_en_i,
  input  logic                     clear_i,
  input  logic                     tracer_valid_i,
  input  logic [TRACE_WIDTH-1:0]   tracer_data_i,
  output logic                     tracer_ready_o,
  output logic [TRACE_WIDTH-1:0]   trace_out_o,
  output logic                     trace_ready_o,
  input  logic                     trace_pop_i,
  output logic                     trace_capture_enable_o,
  output logic                     lock_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_C   = OW'(DEPTH);
  localparam logic [OW-1:0] LOCK_HI_C = OW'(LOCK_HI);
  localparam logic [OW-1:0] LOCK_LO_C = OW'(LOCK_LO);

  logic [TRACE_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r, rd_ptr_r;
  logic [OW-1:0]          occ_r;
  logic                   lock_r, overflow_r, cap_en_r;
  logic [15:0]            drop_cnt_r;

  logic                   offer_s, full_s, empty_s, push_s, pop_s, drop_s;
  logic [AW-1:0]          wr_ptr_next_s, rd_ptr_next_s;
  logic [OW-1:0]          occ_next_s;
  logic                   lock_next_s, overflow_next_s;
  logic [15:0]            drop_cnt_next_s;

  // Transfer qualification and next-state for pointers, occupancy and status
  always_comb begin
    offer_s         = tracer_valid_i & capture_en_i;
    full_s          = (occ_r == DEPTH_C);
    empty_s         = (occ_r == {OW{1'b0}});
    push_s          = offer_s & ~full_s;
    drop_s          = offer_s & full_s;
    pop_s           = trace_pop_i & ~empty_s;
    wr_ptr_next_s   = wr_ptr_r;
    rd_ptr_next_s   = rd_ptr_r;
    occ_next_s      = occ_r;
    lock_next_s     = lock_r;
    overflow_next_s = overflow_r;
    drop_cnt_next_s = drop_cnt_r;

    if (clear_i) begin
      wr_ptr_next_s   = {AW{1'b0}};
      rd_ptr_next_s   = {AW{1'b0}};
      occ_next_s      = {OW{1'b0}};
      lock_next_s     = 1'b0;
      overflow_next_s = 1'b0;
      drop_cnt_next_s = 16'h0000;
    end else begin
      if (push_s) begin
        wr_ptr_next_s = wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_next_s = rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      if (push_s && !pop_s) begin
        occ_next_s = occ_r + OW'(1);
      end else if (pop_s && !push_s) begin
        occ_next_s = occ_r - OW'(1);
      end else begin
        occ_next_s = occ_r;
      end
      // Hysteresis acts on the post-edge occupancy so lock moves with the transfer
      if (occ_next_s >= LOCK_HI_C) begin
        lock_next_s = 1'b1;
      end else if (occ_next_s <= LOCK_LO_C) begin
        lock_next_s = 1'b0;
      end else begin
        lock_next_s = lock_r;
      end
      overflow_next_s = overflow_r | drop_s;
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_next_s = drop_cnt_r + 16'h0001;
      end else begin
        drop_cnt_next_s = drop_cnt_r;
      end
    end
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      occ_r      <= {OW{1'b0}};
      lock_r     <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'h0000;
      cap_en_r   <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_next_s;
      rd_ptr_r   <= rd_ptr_next_s;
      occ_r      <= occ_next_s;
      lock_r     <= lock_next_s;
      overflow_r <= overflow_next_s;
      drop_cnt_r <= drop_cnt_next_s;
      cap_en_r   <= capture_en_i & ~overflow_next_s;
    end
  end

  // Record storage; contents are don't-care after clear or reset
  always_ff @(posedge clk) begin
    if (push_s && !clear_i) begin
      mem_r[wr_ptr_r] <= tracer_data_i;
    end
  end

  assign trace_out_o            = mem_r[rd_ptr_r];
  assign trace_ready_o          = (occ_r != {OW{1'b0}});
  assign tracer_ready_o         = (occ_r != DEPTH_C);
  assign occupancy_o            = occ_r;
  assign lock_o                 = lock_r;
  assign overflow_o             = overflow_r;
  assign drop_count_o           = drop_cnt_r;
  assign trace_capture_enable_o = cap_en_r;

endmodule
